// File: rtl/shift_register_controller_if.sv
// Handshake and data bundle between the lab inputs and the shift-register sequencer.
interface shift_register_controller_if #(
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             start;
  logic [WIDTH-1:0] data;
  logic             serial_in;
  logic             serial_out;
  logic [WIDTH-1:0] parallel_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bit_count;

  // Requester side: issues start/data and feeds the serial input.
  modport master (
    output start, data, serial_in,
    input  serial_out, parallel_out, busy, done, bit_count
  );

  // Sequencer side.
  modport slave (
    input  start, data, serial_in,
    output serial_out, parallel_out, busy, done, bit_count
  );
endinterface

// File: rtl/shift_register_controller.sv
// Sequencer for a WIDTH-bit PISO/SIPO flip-flop chain: loads a word on start,
// shifts it out MSB-first holding each bit HOLD clocks, captures serial_in
// into the LSB, then pulses done for one cycle.
module shift_register_controller #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned HOLD  = 1
) (
  input logic                     clockpulse,
  input logic                     clear,
  shift_register_controller_if.slave bus
);

  localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
  localparam int unsigned HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_shift = 2'd1,
    st_done  = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   shreg_q;
  logic [HOLD_W-1:0]  hold_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;

  logic               hold_last;
  logic               shift_last;

  // Hold window ends this cycle / this shift completes the word.
  assign hold_last  = (hold_q == HOLD_W'(HOLD - 1));
  assign shift_last = (cnt_q == CNT_W'(WIDTH - 1));

  // Sequencer state, shift chain, counters and status flags.
  always_ff @(posedge clockpulse or negedge clear) begin
    if (!clear) begin
      state_q <= st_idle;
      shreg_q <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        st_idle: begin
          if (bus.start) begin
            shreg_q <= bus.data;
            cnt_q   <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= st_shift;
          end
        end

        st_shift: begin
          if (hold_last) begin
            shreg_q <= {shreg_q[WIDTH-2:0], bus.serial_in};
            cnt_q   <= cnt_q + CNT_W'(1);
            hold_q  <= '0;
            if (shift_last) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= st_done;
            end
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end

        st_done: begin
          done_q <= 1'b0;
          // A start here chains straight into the next word with no idle gap.
          if (bus.start) begin
            shreg_q <= bus.data;
            cnt_q   <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= st_shift;
          end else begin
            state_q <= st_idle;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= st_idle;
        end
      endcase
    end
  end

  // MSB is only presented while shifting; gated from registered state.
  assign bus.serial_out   = busy_q & shreg_q[WIDTH-1];
  assign bus.parallel_out = shreg_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.bit_count    = cnt_q;

endmodule

// File: tb/tb_shift_register_controller.sv
// Self-checking bench: two instances (HOLD=1, HOLD=2) share stimulus; sel picks
// which one a scenario checks against a word-level reference model.
module tb_shift_register_controller;

  logic       clk;
  logic       clear;
  logic       start;
  logic [3:0] data;
  logic       serial_in;
  logic       sel;

  int n_vec;
  int n_err;

  shift_register_controller_if #(.WIDTH(4)) if1 ();
  shift_register_controller_if #(.WIDTH(4)) if2 ();

  assign if1.start     = start;
  assign if1.data      = data;
  assign if1.serial_in = serial_in;
  assign if2.start     = start;
  assign if2.data      = data;
  assign if2.serial_in = serial_in;

  shift_register_controller #(.WIDTH(4), .HOLD(1)) u_dut_h1 (
    .clockpulse (clk),
    .clear      (clear),
    .bus        (if1)
  );

  shift_register_controller #(.WIDTH(4), .HOLD(2)) u_dut_h2 (
    .clockpulse (clk),
    .clear      (clear),
    .bus        (if2)
  );

  logic       so_w;
  logic [3:0] po_w;
  logic       busy_w;
  logic       done_w;
  logic [2:0] bc_w;

  always_comb begin
    so_w   = sel ? if2.serial_out   : if1.serial_out;
    po_w   = sel ? if2.parallel_out : if1.parallel_out;
    busy_w = sel ? if2.busy         : if1.busy;
    done_w = sel ? if2.done         : if1.done;
    bc_w   = sel ? if2.bit_count    : if1.bit_count;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle();
    start = 1'b0;
    repeat (12) step();
  endtask

  // One operation from a start edge through DONE (and one IDLE cycle unless chaining).
  // sin_mode: 0 constant sin_val, 1 random, 2 loopback.
  task automatic run_op(input logic [3:0] d, input int sin_mode, input logic sin_val,
                        input bit inject, input bit chain, input logic [3:0] next_d);
    int h;
    int n;
    int j;
    logic [3:0] cap;
    logic [3:0] md;
    h   = sel ? 2 : 1;
    n   = 4 * h;
    cap = 4'b0000;
    start     = 1'b1;
    data      = d;
    serial_in = 1'b0;
    step();
    start = 1'b0;
    data  = 4'($urandom);
    for (int k = 1; k <= n; k++) begin
      j  = (k - 1) / h;
      md = (d << j) | cap;
      n_vec++; if (busy_w !== 1'b1) begin n_err++; $display("FAIL busy h=%0d d=%b cyc=%0d got=%b exp=1", h, d, k, busy_w); end
      n_vec++; if (done_w !== 1'b0) begin n_err++; $display("FAIL done_early h=%0d d=%b cyc=%0d got=%b exp=0", h, d, k, done_w); end
      n_vec++; if (so_w !== md[3]) begin n_err++; $display("FAIL serial_out h=%0d d=%b cyc=%0d got=%b exp=%b", h, d, k, so_w, md[3]); end
      n_vec++; if (po_w !== md) begin n_err++; $display("FAIL parallel_out h=%0d d=%b cyc=%0d got=%b exp=%b", h, d, k, po_w, md); end
      n_vec++; if (bc_w !== 3'(j)) begin n_err++; $display("FAIL bit_count h=%0d d=%b cyc=%0d got=%0d exp=%0d", h, d, k, bc_w, j); end
      case (sin_mode)
        0:       serial_in = sin_val;
        1:       serial_in = 1'($urandom);
        default: serial_in = md[3];
      endcase
      if (k % h == 0) cap = {cap[2:0], serial_in};
      if (inject && k == 2) begin start = 1'b1; data = 4'b1111; end
      else if (inject && k == 3) start = 1'b0;
      if (chain && k == n) begin start = 1'b1; data = next_d; end
      step();
    end
    n_vec++; if (done_w !== 1'b1) begin n_err++; $display("FAIL done_pulse h=%0d d=%b got=%b exp=1", h, d, done_w); end
    n_vec++; if (busy_w !== 1'b0) begin n_err++; $display("FAIL busy_done h=%0d d=%b got=%b exp=0", h, d, busy_w); end
    n_vec++; if (so_w !== 1'b0) begin n_err++; $display("FAIL serial_out_done h=%0d d=%b got=%b exp=0", h, d, so_w); end
    n_vec++; if (po_w !== cap) begin n_err++; $display("FAIL captured h=%0d d=%b got=%b exp=%b", h, d, po_w, cap); end
    n_vec++; if (bc_w !== 3'd4) begin n_err++; $display("FAIL bit_count_done h=%0d d=%b got=%0d exp=4", h, d, bc_w); end
    if (!chain) begin
      start = 1'b0;
      data  = 4'($urandom);
      step();
      n_vec++; if (done_w !== 1'b0) begin n_err++; $display("FAIL done_width h=%0d d=%b got=%b exp=0", h, d, done_w); end
      n_vec++; if (busy_w !== 1'b0) begin n_err++; $display("FAIL busy_idle h=%0d d=%b got=%b exp=0", h, d, busy_w); end
      n_vec++; if (po_w !== cap) begin n_err++; $display("FAIL held_idle h=%0d d=%b got=%b exp=%b", h, d, po_w, cap); end
      n_vec++; if (bc_w !== 3'd4) begin n_err++; $display("FAIL bit_count_idle h=%0d d=%b got=%0d exp=4", h, d, bc_w); end
    end
  endtask

  task automatic test_reset();
    clear = 1'b0;
    start = 1'b0;
    data  = 4'b1010;
    serial_in = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (if1.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy_h1 got=%b exp=0", if1.busy); end
    n_vec++; if (if1.done !== 1'b0) begin n_err++; $display("FAIL rst_done_h1 got=%b exp=0", if1.done); end
    n_vec++; if (if1.serial_out !== 1'b0) begin n_err++; $display("FAIL rst_so_h1 got=%b exp=0", if1.serial_out); end
    n_vec++; if (if1.parallel_out !== 4'b0000) begin n_err++; $display("FAIL rst_po_h1 got=%b exp=0000", if1.parallel_out); end
    n_vec++; if (if1.bit_count !== 3'd0) begin n_err++; $display("FAIL rst_bc_h1 got=%0d exp=0", if1.bit_count); end
    n_vec++; if (if2.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy_h2 got=%b exp=0", if2.busy); end
    n_vec++; if (if2.done !== 1'b0) begin n_err++; $display("FAIL rst_done_h2 got=%b exp=0", if2.done); end
    n_vec++; if (if2.serial_out !== 1'b0) begin n_err++; $display("FAIL rst_so_h2 got=%b exp=0", if2.serial_out); end
    n_vec++; if (if2.parallel_out !== 4'b0000) begin n_err++; $display("FAIL rst_po_h2 got=%b exp=0000", if2.parallel_out); end
    n_vec++; if (if2.bit_count !== 3'd0) begin n_err++; $display("FAIL rst_bc_h2 got=%0d exp=0", if2.bit_count); end
    clear = 1'b1;
    // IDLE with start low: nothing moves while data and serial_in toggle.
    for (int i = 0; i < 4; i++) begin
      data = 4'($urandom);
      serial_in = 1'($urandom);
      step();
      n_vec++; if (if1.parallel_out !== 4'b0000 || if1.busy !== 1'b0 || if1.done !== 1'b0)
        begin n_err++; $display("FAIL idle_quiet cyc=%0d po=%b busy=%b done=%b exp=0000/0/0", i, if1.parallel_out, if1.busy, if1.done); end
    end
  endtask

  task automatic test_basic();
    sel = 1'b0;
    settle();
    run_op(4'b1011, 0, 1'b0, 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic test_loopback();
    sel = 1'b0;
    settle();
    run_op(4'b0110, 2, 1'b0, 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic test_hold2();
    sel = 1'b1;
    settle();
    run_op(4'b1000, 0, 1'b1, 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic test_start_ignored();
    sel = 1'b0;
    settle();
    run_op(4'b1010, 0, 1'b0, 1'b1, 1'b0, 4'b0000);
    sel = 1'b1;
    settle();
    run_op(4'b0011, 1, 1'b0, 1'b1, 1'b0, 4'b0000);
  endtask

  task automatic test_clear_midshift();
    sel = 1'b1;
    settle();
    start = 1'b1;
    data  = 4'b1011;
    serial_in = 1'b1;
    step();
    start = 1'b0;
    step();
    #2;
    clear = 1'b0;
    #1;
    n_vec++; if (busy_w !== 1'b0) begin n_err++; $display("FAIL clr_busy got=%b exp=0", busy_w); end
    n_vec++; if (so_w !== 1'b0) begin n_err++; $display("FAIL clr_so got=%b exp=0", so_w); end
    n_vec++; if (po_w !== 4'b0000) begin n_err++; $display("FAIL clr_po got=%b exp=0000", po_w); end
    n_vec++; if (bc_w !== 3'd0) begin n_err++; $display("FAIL clr_bc got=%0d exp=0", bc_w); end
    n_vec++; if (done_w !== 1'b0) begin n_err++; $display("FAIL clr_done got=%b exp=0", done_w); end
    step();
    clear = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++; if (done_w !== 1'b0 || busy_w !== 1'b0 || bc_w !== 3'd0 || po_w !== 4'b0000)
        begin n_err++; $display("FAIL post_clr cyc=%0d done=%b busy=%b bc=%0d po=%b exp=0/0/0/0000", i, done_w, busy_w, bc_w, po_w); end
    end
    run_op(4'b1101, 1, 1'b0, 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    settle();
    run_op(4'b1001, 1, 1'b0, 1'b0, 1'b1, 4'b0101);
    run_op(4'b0101, 0, 1'b1, 1'b0, 1'b0, 4'b0000);
    sel = 1'b1;
    settle();
    run_op(4'b1110, 1, 1'b0, 1'b0, 1'b1, 4'b0101);
    run_op(4'b0101, 2, 1'b0, 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic test_random();
    logic [3:0] d;
    logic [3:0] nd;
    bit inj;
    bit ch;
    for (int it = 0; it < 24; it++) begin
      sel = 1'($urandom);
      settle();
      d   = 4'($urandom);
      nd  = 4'($urandom);
      inj = 1'($urandom);
      ch  = ($urandom_range(0, 3) == 0);
      run_op(d, int'($urandom_range(0, 2)), 1'($urandom), inj, ch, nd);
      if (ch) run_op(nd, 1, 1'b0, 1'b0, 1'b0, 4'b0000);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    sel = 1'b0;
    test_reset();
    test_basic();
    test_loopback();
    test_hold2();
    test_start_ignored();
    test_clear_midshift();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_register_controller.md
Name: shift_register_controller

Overview:
Sequencer for a WIDTH-bit chain of D flip-flops operated as a parallel-in/serial-out and serial-in/parallel-out shift register. On start it loads a parallel word, shifts it out MSB-first, one bit per HOLD clocks, and captures serial_in into the LSB. It then reports completion with a one-cycle done pulse. It sits between the lab's switch/pushbutton inputs and the flip-flop chain, and it replaces manual clockpulse toggling in the bench.

Parameters:
WIDTH, 4, number of flip-flops in the chain (legal range 2..16)
HOLD, 1, clocks each bit is held on serial_out before the next shift (legal range 1..255)

Ports:
clockpulse  input  1  rising-edge clock
clear  input  1  asynchronous, active-low reset; clear=0 resets the block immediately
start  input  1  request to load data and begin shifting; sampled on the rising edge
data  input  WIDTH  parallel word loaded when start is accepted
serial_in  input  1  bit shifted into the LSB on each shift
serial_out  output  1  MSB of the shift register while busy, else 0
parallel_out  output  WIDTH  current shift-register contents
busy  output  1  high in SHIFT state
done  output  1  one-cycle pulse in DONE state
bit_count  output  $clog2(WIDTH+1)  number of shifts completed in the current operation

Behaviour:
- Reset (clear=0, asynchronous, any state): state=IDLE, shreg=0, hold counter=0, bit_count=0, serial_out=0, busy=0, done=0. Any operation in progress is aborted; no partial done is issued.
- After clear deasserts, the first rising edge is processed normally.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge: shreg<=data, bit_count<=0, hold<=0, next state=SHIFT.
  - start=0: remain in IDLE; shreg is held.
- SHIFT:
  - busy=1; serial_out=shreg[WIDTH-1] (combinational from register).
  - Each edge: if hold==HOLD-1, then shreg<={shreg[WIDTH-2:0],serial_in}, bit_count++, hold<=0; otherwise hold++.
  - The shift that makes bit_count==WIDTH moves the state to DONE.
  - SHIFT lasts exactly WIDTH*HOLD cycles.
  - start is ignored in SHIFT; data changes have no effect.
- DONE:
  - Lasts one cycle; done=1, busy=0, serial_out=0.
  - parallel_out holds the WIDTH captured serial_in bits, with the first captured bit at the MSB.
  - bit_count=WIDTH.
  - start=1 at the DONE edge: new load, next state SHIFT (back-to-back, no IDLE gap). Otherwise next state IDLE.
- Latency: the start edge is cycle 0. First bit is on serial_out during cycles 1..HOLD. done is high in cycle WIDTH*HOLD+1.
- parallel_out=shreg in all states; shreg is held in IDLE until the next accepted start.
- bit_count saturates at WIDTH and keeps that value in DONE and IDLE until the next accepted start clears it.
- No other outputs change in IDLE.

Test Plan:
- WIDTH=4, HOLD=1, data=4'b1011, serial_in=0, one-cycle start -> serial_out=1,0,1,1 in cycles 1-4, busy high in cycles 1-4, done pulse in cycle 5, parallel_out=4'b0000, bit_count=4.
- Loopback (serial_in=serial_out), data=4'b0110 -> at done, parallel_out=4'b0110.
- HOLD=2, data=4'b1000, serial_in=1 -> serial_out high in cycles 1-2 and low in cycles 3-8, done in cycle 9, parallel_out=4'b1111.
- start pulsed in cycle 2 of a shift with data=4'b1111 -> ignored; output sequence and done timing unchanged.
- clear=0 asserted mid-SHIFT (between edges) -> busy, serial_out, parallel_out, bit_count go to 0 immediately without a clock; no done pulse; after release, state is IDLE.
- start held high through DONE with data=4'b0101 -> busy reasserts in the cycle after done, and serial_out=0,1,0,1 follows with no idle cycle.
